// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit holding the architectural HI/LO registers of
// the MIPS core. Operands arrive straight from the register file (rs, rt).
// MULT/MULTU run a shift-add multiply and DIV/DIVU a restoring divide. Both
// work on unsigned magnitudes for WIDTH cycles, then one fix-up cycle applies
// the sign correction and writes HI/LO.
//
// Timeline (E0 = the edge on which Start is accepted in IDLE):
//   E0             latch magnitudes and signs, Busy rises
//   E0+1..E0+W     one iteration per edge (CALC)
//   E0+W+1         sign fix, HI/LO written, Done pulses, Busy falls (FIX)
//   E0+W+2         next Start may be accepted
//
// Ports
//   i_clock       system clock, all state changes on posedge
//   i_reset       asynchronous active-high reset, clears all state
//   i_start       launch operation i_op (only sampled in IDLE)
//   i_op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operand_a   rs value (multiplicand / dividend)
//   i_operand_b   rt value (multiplier / divisor)
//   i_write_hi    MTHI: HI <= i_write_data (IDLE only)
//   i_write_lo    MTLO: LO <= i_write_data (IDLE only)
//   i_write_data  data for MTHI/MTLO
//   o_hi          HI register (product high / remainder)
//   o_lo          LO register (product low / quotient)
//   o_busy        high while an operation is in flight
//   o_done        one-cycle pulse when HI/LO have just taken a result
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_write_hi,
    input  logic             i_write_lo,
    input  logic [WIDTH-1:0] i_write_data,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CW-1:0]    r_counter;
    logic             r_is_div;     // divide (1) or multiply (0) in flight
    logic             r_neg_lo;     // negate product / quotient at fix-up
    logic             r_neg_hi;     // negate remainder at fix-up (dividend sign)
    logic             r_div_zero;   // divisor was zero
    logic [WIDTH-1:0] r_a_raw;      // original dividend, returned on divide by zero
    logic [WIDTH-1:0] r_operand;    // multiplicand magnitude or divisor magnitude
    // Working accumulator. Multiply: {hi, lo} is the partial product with the
    // multiplier shifting out of lo. Divide: hi is the partial remainder and
    // lo shifts dividend bits out the top while quotient bits enter the bottom.
    // The extra top bit of r_acc_hi is always zero between iterations.
    logic [WIDTH:0]   r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------
    // Operand conditioning at launch
    // ------------------------------------------------------------------
    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed_op = ~i_op[0];
    assign w_a_neg     = w_signed_op & i_operand_a[WIDTH-1];
    assign w_b_neg     = w_signed_op & i_operand_b[WIDTH-1];
    // Negating the most-negative value yields 2^(WIDTH-1), which is exactly
    // right when the result is read as an unsigned magnitude.
    assign w_a_mag     = w_a_neg ? (~i_operand_a + WIDTH'(1)) : i_operand_a;
    assign w_b_mag     = w_b_neg ? (~i_operand_b + WIDTH'(1)) : i_operand_b;

    // ------------------------------------------------------------------
    // One multiply iteration: add multiplicand if the current multiplier
    // bit is set, then shift the whole {sum, lo} pair right by one.
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_mul_sum;

    assign w_mul_sum = r_acc_hi + (r_acc_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});

    // ------------------------------------------------------------------
    // One restoring-divide iteration: shift next dividend bit into the
    // remainder, trial-subtract the divisor, keep the difference if it did
    // not go negative. Two guard bits make the borrow visible.
    // ------------------------------------------------------------------
    logic [WIDTH+1:0] w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_neg;

    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_operand};
    assign w_div_neg   = w_div_diff[WIDTH+1];

    // ------------------------------------------------------------------
    // Fix-up: sign correction and special cases
    // ------------------------------------------------------------------
    logic [W2-1:0]    w_prod;
    logic [W2-1:0]    w_prod_fixed;
    logic [WIDTH-1:0] w_quot_fixed;
    logic [WIDTH-1:0] w_rem_fixed;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_prod       = {r_acc_hi[WIDTH-1:0], r_acc_lo};
    assign w_prod_fixed = r_neg_lo ? (~w_prod + W2'(1)) : w_prod;
    assign w_quot_fixed = r_neg_lo ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
    assign w_rem_fixed  = r_neg_hi ? (~r_acc_hi[WIDTH-1:0] + WIDTH'(1)) : r_acc_hi[WIDTH-1:0];

    always_comb begin
        w_fix_hi = w_prod_fixed[W2-1:WIDTH];
        w_fix_lo = w_prod_fixed[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                // No trap on divide by zero: HI keeps the dividend as given,
                // LO saturates to all ones.
                w_fix_hi = r_a_raw;
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_hi = w_rem_fixed;
                w_fix_lo = w_quot_fixed;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_counter  <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            r_operand  <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // MTHI/MTLO land here even when Start is also high; the
                    // result of that new operation overwrites them at fix-up.
                    if (i_write_hi) r_hi <= i_write_data;
                    if (i_write_lo) r_lo <= i_write_data;
                    if (i_start) begin
                        r_is_div   <= i_op[1];
                        r_div_zero <= i_op[1] & (i_operand_b == '0);
                        r_a_raw    <= i_operand_a;
                        r_neg_lo   <= w_a_neg ^ w_b_neg;
                        r_neg_hi   <= w_a_neg;
                        r_acc_hi   <= '0;
                        if (i_op[1]) begin
                            r_acc_lo  <= w_a_mag;
                            r_operand <= w_b_mag;
                        end else begin
                            r_acc_lo  <= w_b_mag;
                            r_operand <= w_a_mag;
                        end
                        r_counter  <= CW'(WIDTH);
                        r_busy     <= 1'b1;
                        r_state    <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_div_neg ? w_div_shift[WIDTH:0] : w_div_diff[WIDTH:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_div_neg};
                    end else begin
                        r_acc_hi <= {1'b0, w_mul_sum[WIDTH:1]};
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    r_counter <= r_counter - CW'(1);
                    if (r_counter == CW'(1)) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH = 32). Inputs are driven on the falling
// edge and outputs sampled on the falling edge, away from the active edge.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op_sel = 2'd0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_op         (op_sel),
        .i_operand_a  (opa),
        .i_operand_b  (opb),
        .i_write_hi   (wr_hi),
        .i_write_lo   (wr_lo),
        .i_write_data (wr_data),
        .o_hi         (hi),
        .o_lo         (lo),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] e_hi, output logic [31:0] e_lo);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        if (op == 2'd0) begin
            p = sa * sb;
        end else if (op == 2'd1) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (op == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {a % b, a / b};
        end
        e_hi = p[63:32];
        e_lo = p[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned s;
        s = $urandom_range(0, 7);
        case (s)
            0: pick_operand = 32'h8000_0000;
            1: pick_operand = 32'hFFFF_FFFF;
            2: pick_operand = 32'd0;
            3: pick_operand = 32'($urandom_range(0, 20));
            default: pick_operand = $urandom;
        endcase
    endfunction

    // Launch one operation (called at a falling edge) and follow it until
    // Done. Measures latency and whether Busy/HI/LO behaved while in flight.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output bit hold_ok, output bit busy_ok);
        logic [31:0] pre_hi, pre_lo;
        pre_hi  = hi;
        pre_lo  = lo;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        lat     = 0;
        start   = 1'b1;
        op_sel  = op;
        opa     = a;
        opb     = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        opa   = $urandom;   // operands must have been captured already
        opb   = $urandom;
        op_sel = 2'($urandom_range(0, 3));
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        r_hi = hi;
        r_lo = lo;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (hi !== 32'd0)  begin failures++; $display("FAIL reset_hi actual=%h required=%h", hi, 32'd0); end
        checks++; if (lo !== 32'd0)  begin failures++; $display("FAIL reset_lo actual=%h required=%h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spec_vectors();
        logic [1:0]  v_op [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
        logic [31:0] v_a  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9};
        logic [31:0] v_b  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] v_hi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd100, 32'hFFFF_FFF9};
        logic [31:0] v_lo [6] = '{32'hFFFF_FFEB, 32'd1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat;
        logic [31:0] r_hi, r_lo;
        bit hold_ok, busy_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], lat, r_hi, r_lo, hold_ok, busy_ok);
            $display("vector %0d op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", i, v_op[i], v_a[i], v_b[i], r_hi, r_lo, lat);
            checks++; if (lat != LAT)      begin failures++; $display("FAIL vec%0d_latency actual=%0d required=%0d", i, lat, LAT); end
            checks++; if (r_hi !== v_hi[i]) begin failures++; $display("FAIL vec%0d_hi actual=%h required=%h", i, r_hi, v_hi[i]); end
            checks++; if (r_lo !== v_lo[i]) begin failures++; $display("FAIL vec%0d_lo actual=%h required=%h", i, r_lo, v_lo[i]); end
            checks++; if (!hold_ok)         begin failures++; $display("FAIL vec%0d_hold actual=changed required=held", i); end
            checks++; if (!busy_ok)         begin failures++; $display("FAIL vec%0d_busy actual=wrong required=high_until_done", i); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (done !== 1'b0)    begin failures++; $display("FAIL vec%0d_done_width actual=%b required=0", i, done); end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0]  r_op;
        logic [31:0] a, b, r_hi, r_lo, e_hi, e_lo;
        bit hold_ok, busy_ok;
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            ref_model(r_op, a, b, e_hi, e_lo);
            run_op(r_op, a, b, lat, r_hi, r_lo, hold_ok, busy_ok);
            $display("random %0d op=%0d a=%h b=%h hi=%h lo=%h", i, r_op, a, b, r_hi, r_lo);
            checks++; if (lat != LAT)   begin failures++; $display("FAIL rand%0d_latency actual=%0d required=%0d", i, lat, LAT); end
            checks++; if (r_hi !== e_hi) begin failures++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h actual=%h required=%h", i, r_op, a, b, r_hi, e_hi); end
            checks++; if (r_lo !== e_lo) begin failures++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h actual=%h required=%h", i, r_op, a, b, r_lo, e_lo); end
            checks++; if (!hold_ok || !busy_ok) begin failures++; $display("FAIL rand%0d_inflight actual=hold%0d_busy%0d required=hold1_busy1", i, hold_ok, busy_ok); end
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2, e1h, e1l, e2h, e2l;
        bit ho1, bo1, ho2, bo2;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        ref_model(2'd1, a1, b1, e1h, e1l);
        ref_model(2'd2, a2, b2, e2h, e2l);
        run_op(2'd1, a1, b1, lat1, h1, l1, ho1, bo1);
        // Second Start goes in on the edge right after the Done cycle.
        run_op(2'd2, a2, b2, lat2, h2, l2, ho2, bo2);
        $display("back_to_back multu=%h_%h div=%h_%h", h1, l1, h2, l2);
        checks++; if ({h1, l1} !== {e1h, e1l}) begin failures++; $display("FAIL b2b_first actual=%h%h required=%h%h", h1, l1, e1h, e1l); end
        checks++; if ({h2, l2} !== {e2h, e2l}) begin failures++; $display("FAIL b2b_second actual=%h%h required=%h%h", h2, l2, e2h, e2l); end
        checks++; if (lat2 != LAT || !bo2)     begin failures++; $display("FAIL b2b_accept actual=lat%0d_busy%0d required=lat%0d_busy1", lat2, bo2, LAT); end
    endtask

    task automatic test_ignore_while_busy();
        int lat;
        logic [31:0] pre_lo;
        bit hold_ok;
        hold_ok = 1'b1;
        pre_lo  = lo;
        start = 1'b1; op_sel = 2'd0; opa = 32'd5; opb = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            if (lat == 4) begin
                start = 1'b1; op_sel = 2'd3; opa = 32'd9; opb = 32'd3;
                wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
            end else if (lat == 5) begin
                start = 1'b0; wr_lo = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (lo !== pre_lo) hold_ok = 1'b0;
        end
        $display("ignore_while_busy hi=%h lo=%h lat=%0d", hi, lo, lat);
        checks++; if (lat != LAT)     begin failures++; $display("FAIL busy_start_latency actual=%0d required=%0d", lat, LAT); end
        checks++; if (hi !== 32'd0)   begin failures++; $display("FAIL busy_start_hi actual=%h required=%h", hi, 32'd0); end
        checks++; if (lo !== 32'd30)  begin failures++; $display("FAIL busy_start_lo actual=%h required=%h", lo, 32'd30); end
        checks++; if (!hold_ok)       begin failures++; $display("FAIL busy_write_lo actual=changed required=held"); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL busy_start_relaunch actual=%b required=0", busy); end
    endtask

    task automatic test_writes();
        int lat;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        $display("mthi_mtlo hi=%h lo=%h", hi, lo);
        checks++; if (hi !== 32'hCAFE_F00D) begin failures++; $display("FAIL both_write_hi actual=%h required=%h", hi, 32'hCAFE_F00D); end
        checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("FAIL both_write_lo actual=%h required=%h", lo, 32'hCAFE_F00D); end
        // Write and Start in the same idle cycle: write lands now, result later.
        wr_hi = 1'b1; wr_data = 32'h77;
        start = 1'b1; op_sel = 2'd1; opa = 32'd3; opb = 32'd4;
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0; start = 1'b0;
        checks++; if (hi !== 32'h77 || busy !== 1'b1) begin failures++; $display("FAIL start_write_now actual=hi%h_busy%b required=hi00000077_busy1", hi, busy); end
        lat = 0;
        while (lat < 100 && done !== 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        $display("start_with_write hi=%h lo=%h lat=%0d", hi, lo, lat + 1);
        checks++; if ({hi, lo} !== {32'd0, 32'd12}) begin failures++; $display("FAIL start_write_result actual=%h%h required=%h%h", hi, lo, 32'd0, 32'd12); end
    endtask

    task automatic test_reset_midop();
        bit stray_done;
        wr_hi = 1'b1; wr_data = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0;
        checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi actual=%h required=%h", hi, 32'h1234); end
        start = 1'b1; op_sel = 2'd0; opa = 32'd5; opb = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        $display("reset_midop busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL async_reset_busy actual=%b required=0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL async_reset_done actual=%b required=0", done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL async_reset_hilo actual=%h_%h required=0_0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        stray_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
        end
        checks++; if (stray_done) begin failures++; $display("FAIL aborted_op_result actual=activity required=quiet"); end
        wr_lo = 1'b1; wr_data = 32'h55;
        @(posedge clk);
        @(negedge clk);
        wr_lo = 1'b0;
        $display("mtlo_after_reset hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'h55 || hi !== 32'd0) begin failures++; $display("FAIL mtlo_after_reset actual=%h_%h required=00000000_00000055", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_ignore_while_busy();
        test_writes();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
